// File: rtl/load_store_unit.sv
// Load/store unit: turns pipeline load/store requests into single-cycle memory
// accesses on a 16-bit word memory, formats load data and flags misaligned or out-of-range accesses.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_byte_select,
    output logic        mem_byte_enable,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_wait
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCESS, S_CAPTURE, S_FAULT, S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_write;
    logic        r_byte;
    logic        r_signed;
    logic        r_sel;
    logic [15:0] r_word;
    logic [15:0] r_wdata;
    logic [15:0] r_resp_rdata;
    logic        r_resp_fault;

    logic [15:0] w_word;
    logic        w_sel;
    logic        w_fault;
    logic        w_accept;

    assign w_word   = {1'b0, req_addr[15:1]};
    assign w_sel    = req_addr[0];
    assign w_fault  = (!req_byte && w_sel) || ({16'd0, w_word} >= 32'(MEM_WORDS));
    assign w_accept = (r_state == S_IDLE) && req_valid;

    // Byte loads pick the lane by address bit 0, then sign- or zero-extend.
    function automatic logic [15:0] fmt_load(input logic [15:0] rd, input logic is_byte,
                                             input logic sel, input logic sgn);
        logic [7:0] b;
        b = sel ? rd[15:8] : rd[7:0];
        if (!is_byte)
            return rd;
        return {(sgn ? {8{b[7]}} : 8'h00), b};
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (req_valid) w_next = w_fault ? S_FAULT : S_ACCESS;
            S_ACCESS:  if (!mem_wait) w_next = r_write ? S_RESP : S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_FAULT:   w_next = S_RESP;
            S_RESP:    if (resp_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        mem_en     = (r_state == S_ACCESS);
    end

    // Memory-side fields are latched once at acceptance and simply held; mem_en qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
            r_signed     <= 1'b0;
            r_sel        <= 1'b0;
            r_word       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_resp_rdata <= 16'h0000;
            r_resp_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_byte   <= req_byte;
                r_signed <= req_signed;
                r_sel    <= w_sel;
                r_word   <= w_word;
                r_wdata  <= req_byte ? {8'h00, req_wdata[7:0]} : req_wdata;
            end
            case (r_state)
                S_ACCESS: if (!mem_wait && r_write) begin
                    r_resp_rdata <= 16'h0000;
                    r_resp_fault <= 1'b0;
                end
                S_CAPTURE: begin
                    r_resp_rdata <= fmt_load(mem_rdata, r_byte, r_sel, r_signed);
                    r_resp_fault <= 1'b0;
                end
                S_FAULT: begin
                    r_resp_rdata <= 16'h0000;
                    r_resp_fault <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_we          = r_write;
    assign mem_byte_enable = r_byte;
    assign mem_byte_select = r_sel;
    assign mem_addr        = r_word;
    assign mem_wdata       = r_wdata;
    assign resp_rdata      = r_resp_rdata;
    assign resp_fault      = r_resp_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small registered-read memory model behind it.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_rdata;
    logic        resp_fault;
    logic        mem_en;
    logic        mem_we;
    logic        mem_byte_select;
    logic        mem_byte_enable;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_wait = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:63];
    logic [15:0] cap_addr, cap_wdata;
    logic        cap_we, cap_ben, cap_bsel;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_byte_select(mem_byte_select), .mem_byte_enable(mem_byte_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait)
    );

    always #5 clk = ~clk;

    // Memory completes an access on the edge where mem_en=1 and mem_wait=0; read data appears next cycle.
    always @(posedge clk) begin
        if (mem_en && !mem_wait && mem_addr < 16'd64) begin
            if (mem_we) begin
                if (!mem_byte_enable)
                    mem[mem_addr[5:0]] <= mem_wdata;
                else if (mem_byte_select)
                    mem[mem_addr[5:0]][15:8] <= mem_wdata[7:0];
                else
                    mem[mem_addr[5:0]][7:0] <= mem_wdata[7:0];
            end else begin
                mem_rdata <= mem[mem_addr[5:0]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic b, input logic s,
                          input logic [15:0] a, input logic [15:0] wd,
                          output int lat, output int en_cnt,
                          output logic [15:0] rd, output logic flt);
        req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        en_cnt = 0;
        while (!resp_valid && lat < 20) begin
            if (mem_en) begin
                en_cnt++;
                cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
                cap_ben = mem_byte_enable; cap_bsel = mem_byte_select;
            end
            step();
            lat++;
        end
        rd  = resp_rdata;
        flt = resp_fault;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        int          lat, en, cnt_v, cnt_e;
        logic [15:0] rd;
        logic        flt;

        // rst must win over a request presented during reset
        req_valid = 1'b1; req_addr = 16'h0010;
        step(); step();
        req_valid = 1'b0;
        rst = 1'b0;
        chk("rst_req_ready", 16'(req_ready), 16'h1);
        chk("rst_resp_valid", 16'(resp_valid), 16'h0);
        chk("rst_resp_fault", 16'(resp_fault), 16'h0);
        chk("rst_resp_rdata", resp_rdata, 16'h0000);
        chk("rst_mem_en", 16'(mem_en), 16'h0);
        chk("rst_mem_we", 16'(mem_we), 16'h0);
        chk("rst_mem_ben", 16'(mem_byte_enable), 16'h0);
        chk("rst_mem_bsel", 16'(mem_byte_select), 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);

        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, lat, en, rd, flt);
        chk("st_word_lat", 16'(lat), 16'd2);
        chk("st_word_en", 16'(en), 16'd1);
        chk("st_word_addr", cap_addr, 16'd8);
        chk("st_word_we", 16'(cap_we), 16'h1);
        chk("st_word_wdata", cap_wdata, 16'hBEEF);
        chk("st_word_rdata", rd, 16'h0000);
        chk("st_word_fault", 16'(flt), 16'h0);
        chk("st_word_idle", 16'(req_ready), 16'h1);
        chk("st_word_rv_off", 16'(resp_valid), 16'h0);

        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat, en, rd, flt);
        chk("ld_word_lat", 16'(lat), 16'd3);
        chk("ld_word_en", 16'(en), 16'd1);
        chk("ld_word_addr", cap_addr, 16'd8);
        chk("ld_word_we", 16'(cap_we), 16'h0);
        chk("ld_word_rdata", rd, 16'hBEEF);
        chk("ld_word_fault", 16'(flt), 16'h0);

        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h80F1, lat, en, rd, flt);
        chk("st_80f1_lat", 16'(lat), 16'd2);

        do_req(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, lat, en, rd, flt);
        chk("ld_bhi_s_rdata", rd, 16'hFF80);
        chk("ld_bhi_s_bsel", 16'(cap_bsel), 16'h1);
        chk("ld_bhi_s_ben", 16'(cap_ben), 16'h1);
        chk("ld_bhi_s_lat", 16'(lat), 16'd3);

        do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, en, rd, flt);
        chk("ld_blo_u_rdata", rd, 16'h00F1);
        chk("ld_blo_u_bsel", 16'(cap_bsel), 16'h0);

        do_req(1'b1, 1'b1, 1'b0, 16'h0011, 16'h12AB, lat, en, rd, flt);
        chk("st_byte_ben", 16'(cap_ben), 16'h1);
        chk("st_byte_bsel", 16'(cap_bsel), 16'h1);
        chk("st_byte_wdata", cap_wdata, 16'h00AB);
        chk("st_byte_addr", cap_addr, 16'd8);
        chk("st_byte_lat", 16'(lat), 16'd2);

        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat, en, rd, flt);
        chk("ld_after_bst", rd, 16'hABF1);

        do_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, lat, en, rd, flt);
        chk("flt_mis_en", 16'(en), 16'd0);
        chk("flt_mis_fault", 16'(flt), 16'h1);
        chk("flt_mis_rdata", rd, 16'h0000);
        chk("flt_mis_lat", 16'(lat), 16'd2);

        do_req(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, lat, en, rd, flt);
        chk("flt_oor_en", 16'(en), 16'd0);
        chk("flt_oor_fault", 16'(flt), 16'h1);
        chk("flt_oor_rdata", rd, 16'h0000);

        // Last valid word (index 63) is not a fault
        do_req(1'b1, 1'b1, 1'b0, 16'h007F, 16'h0055, lat, en, rd, flt);
        chk("edge63_fault", 16'(flt), 16'h0);
        chk("edge63_en", 16'(en), 16'd1);
        chk("edge63_addr", cap_addr, 16'd63);

        // Backpressure on both sides; a second request during ACCESS must be ignored
        mem_wait = 1'b1;
        req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 16'h0010;
        req_valid = 1'b1;
        step();
        req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            chk("bp_wait_en", 16'(mem_en), 16'h1);
            chk("bp_wait_addr", mem_addr, 16'd8);
            chk("bp_wait_we", 16'(mem_we), 16'h0);
            chk("bp_wait_ready", 16'(req_ready), 16'h0);
            step();
        end
        mem_wait = 1'b0;
        req_valid = 1'b0;
        chk("bp_go_en", 16'(mem_en), 16'h1);
        step();
        chk("bp_cap_en", 16'(mem_en), 16'h0);
        chk("bp_cap_rv", 16'(resp_valid), 16'h0);
        step();
        for (int i = 0; i < 2; i++) begin
            chk("bp_resp_valid", 16'(resp_valid), 16'h1);
            chk("bp_resp_rdata", resp_rdata, 16'hABF1);
            chk("bp_resp_fault", 16'(resp_fault), 16'h0);
            chk("bp_resp_ready", 16'(req_ready), 16'h0);
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("bp_done_rv", 16'(resp_valid), 16'h0);
        chk("bp_done_ready", 16'(req_ready), 16'h1);
        chk("bp_ignored_addr", mem_addr, 16'd8);
        cnt_v = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) cnt_v++;
            step();
        end
        chk("bp_one_resp", 16'(cnt_v), 16'd0);

        // Reset while the memory is stalling an access
        mem_wait = 1'b1;
        req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0020; req_wdata = 16'h1111;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rma_in_access", 16'(mem_en), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_wait = 1'b0;
        chk("rma_mem_en", 16'(mem_en), 16'h0);
        chk("rma_resp_valid", 16'(resp_valid), 16'h0);
        chk("rma_req_ready", 16'(req_ready), 16'h1);
        chk("rma_mem_addr", mem_addr, 16'h0000);
        cnt_v = 0;
        cnt_e = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) cnt_v++;
            if (mem_en) cnt_e++;
            step();
        end
        chk("rma_no_resp", 16'(cnt_v), 16'd0);
        chk("rma_no_mem_en", 16'(cnt_e), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
